// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: sequences one systolic-array tile (clear, skewed operand feed with bubbles, drain, result strobe)
module sa_feed_ctrl #(
  parameter int HPE       = 64,
  parameter int VPE       = 64,
  parameter int WIDTH     = 8,
  parameter int KW        = 16,
  parameter int DRAIN_CYC = HPE + VPE + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [KW-1:0]          CMD_K,
  input  logic                   OP_VALID,
  output logic                   OP_READY,
  input  logic [WIDTH*HPE-1:0]   OP_A,
  input  logic [WIDTH*VPE-1:0]   OP_B,
  output logic [WIDTH*HPE-1:0]   SA_A,
  output logic [WIDTH*VPE-1:0]   SA_B,
  output logic                   SA_CLR,
  output logic                   RES_VALID,
  output logic                   BUSY
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       r_beat_cnt;
  logic [DW-1:0]       r_drain_cnt;
  logic                r_cmd_ready;
  logic                r_op_ready;
  logic                r_clr;
  logic                r_res_valid;
  logic                r_busy;
  logic                w_accept;
  logic                w_clr;
  logic [KW-1:0]       w_beat_nxt;
  logic [WIDTH*HPE-1:0] w_in_a;
  logic [WIDTH*VPE-1:0] w_in_b;
  assign w_accept   = (r_state == FEED) && OP_VALID;
  assign w_clr      = (r_state == CLEAR);
  assign w_beat_nxt = r_beat_cnt + 1'b1;
  assign w_in_a     = w_accept ? OP_A : '0;
  assign w_in_b     = w_accept ? OP_B : '0;
  assign CMD_READY  = r_cmd_ready;
  assign OP_READY   = r_op_ready;
  assign SA_CLR     = r_clr;
  assign RES_VALID  = r_res_valid;
  assign BUSY       = r_busy;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_cmd_ready <= 1'b1;
      r_op_ready  <= 1'b0;
      r_clr       <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (CMD_VALID) begin
          r_k         <= CMD_K;
          r_beat_cnt  <= '0;
          r_state     <= CLEAR;
          r_clr       <= 1'b1;
          r_busy      <= 1'b1;
          r_cmd_ready <= 1'b0;
        end
        CLEAR: begin
          r_clr       <= 1'b0;
          r_state     <= (r_k != '0) ? FEED : DONE;
          r_op_ready  <= (r_k != '0);
          r_res_valid <= (r_k == '0);
        end
        FEED: if (OP_VALID) begin
          r_beat_cnt <= w_beat_nxt;
          if (w_beat_nxt == r_k) begin
            r_state     <= DRAIN;
            r_drain_cnt <= DW'(DRAIN_CYC);
            r_op_ready  <= 1'b0;
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt - 1'b1;
          if (r_drain_cnt == DW'(1)) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // lane i delays by i+1 cycles so operands meet their partners on the array diagonal
  for (genvar i = 0; i < HPE; i++) begin : g_a
    logic [WIDTH-1:0] r_sh [0:i];
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int s = 0; s <= i; s++) r_sh[s] <= '0;
      end else begin
        r_sh[0] <= w_clr ? '0 : w_in_a[WIDTH*i +: WIDTH];
        for (int s = 1; s <= i; s++) r_sh[s] <= w_clr ? '0 : r_sh[s-1];
      end
    end
    assign SA_A[WIDTH*i +: WIDTH] = r_sh[i];
  end
  for (genvar i = 0; i < VPE; i++) begin : g_b
    logic [WIDTH-1:0] r_sh [0:i];
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int s = 0; s <= i; s++) r_sh[s] <= '0;
      end else begin
        r_sh[0] <= w_clr ? '0 : w_in_b[WIDTH*i +: WIDTH];
        for (int s = 1; s <= i; s++) r_sh[s] <= w_clr ? '0 : r_sh[s-1];
      end
    end
    assign SA_B[WIDTH*i +: WIDTH] = r_sh[i];
  end
endmodule

// File: tb/tb_sa_feed_ctrl.sv
// tb_sa_feed_ctrl: randomized tiles against a cycle-timeline reference model of the feed sequencer
module tb_sa_feed_ctrl;
  localparam int H = 4, V = 4, W = 8, KW = 4, DC = H + V + 1, N = 4096, D = (H < V) ? H : V;
  logic CLK = 0, RST = 1, CMD_VALID = 0, OP_VALID = 0;
  logic [KW-1:0] CMD_K = '0;
  logic [W*H-1:0] OP_A = '0;
  logic [W*V-1:0] OP_B = '0;
  logic CMD_READY, OP_READY, SA_CLR, RES_VALID, BUSY;
  logic [W*H-1:0] SA_A;
  logic [W*V-1:0] SA_B;
  sa_feed_ctrl #(.HPE(H), .VPE(V), .WIDTH(W), .KW(KW), .DRAIN_CYC(DC)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_K(CMD_K),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_A(OP_A), .OP_B(OP_B),
    .SA_A(SA_A), .SA_B(SA_B), .SA_CLR(SA_CLR), .RES_VALID(RES_VALID), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  int checks = 0, failures = 0;
  // model: absolute cycle numbers of the tile's events plus a history of what entered the array
  int cyc = 0, floor_c = 0, m_clr_cyc = -1, m_feed_start = -1, m_left = 0, m_res_cyc = -1;
  bit m_active = 0;
  logic [W*H-1:0] ha [N];
  logic [W*V-1:0] hb [N];
  longint m_sum [D];
  longint acc [D];
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W*H-1:0] exp_a(int c);
    logic [W*H-1:0] e = '0;
    for (int i = 0; i < H; i++)
      if (c - i - 1 >= floor_c && c - i - 1 >= 0) e[W*i +: W] = ha[(c - i - 1) % N][W*i +: W];
    return e;
  endfunction
  function automatic logic [W*V-1:0] exp_b(int c);
    logic [W*V-1:0] e = '0;
    for (int j = 0; j < V; j++)
      if (c - j - 1 >= floor_c && c - j - 1 >= 0) e[W*j +: W] = hb[(c - j - 1) % N][W*j +: W];
    return e;
  endfunction
  task automatic tick();
    bit was_active = m_active;
    bit op_rdy = m_active && cyc >= m_feed_start && m_left > 0;
    logic [W*H-1:0] va = '0;
    logic [W*V-1:0] vb = '0;
    chk("cmd_ready", CMD_READY, !m_active);
    chk("busy", BUSY, m_active);
    chk("sa_clr", SA_CLR, cyc == m_clr_cyc);
    chk("op_ready", OP_READY, op_rdy);
    chk("res_valid", RES_VALID, cyc == m_res_cyc);
    chk("sa_a", SA_A, exp_a(cyc));
    chk("sa_b", SA_B, exp_b(cyc));
    if (cyc == m_res_cyc)
      for (int i = 0; i < D; i++) chk("yy_diag", acc[i], m_sum[i]);
    for (int i = 0; i < D; i++)
      acc[i] = SA_CLR ? 0 : acc[i] + longint'(SA_A[W*i +: W]) * longint'(SA_B[W*i +: W]);
    if (op_rdy && OP_VALID) begin
      va = OP_A;
      vb = OP_B;
      m_left--;
      for (int i = 0; i < D; i++) m_sum[i] += longint'(OP_A[W*i +: W]) * longint'(OP_B[W*i +: W]);
      if (m_left == 0) m_res_cyc = cyc + 1 + DC;
    end
    ha[cyc % N] = va;
    hb[cyc % N] = vb;
    if (cyc == m_res_cyc) m_active = 0;
    else if (!was_active && CMD_VALID) begin
      m_active = 1;
      m_clr_cyc = cyc + 1;
      m_feed_start = cyc + 2;
      m_left = int'(CMD_K);
      m_res_cyc = (CMD_K == '0) ? cyc + 2 : -1;
      for (int i = 0; i < D; i++) m_sum[i] = 0;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_sa_a"}, SA_A, '0);
    chk({tag, "_sa_b"}, SA_B, '0);
    chk({tag, "_sa_clr"}, SA_CLR, 0);
    chk({tag, "_res_valid"}, RES_VALID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_op_ready"}, OP_READY, 0);
    chk({tag, "_cmd_ready"}, CMD_READY, 1);
  endtask
  // mode 0: OP_VALID always high; 1: random; 2: low only on the second FEED cycle
  task automatic run_tile(int k, int mode, bit hold, bit rst_in_drain);
    int n = 0;
    bit seen = 0;
    CMD_VALID = 1;
    CMD_K = KW'(k);
    while (n < 400 && !(seen && !m_active)) begin
      OP_VALID = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : (cyc != m_feed_start + 1);
      for (int i = 0; i < H; i++) OP_A[W*i +: W] = W'($urandom);
      for (int j = 0; j < V; j++) OP_B[W*j +: W] = W'($urandom);
      if (rst_in_drain && m_active && m_left == 0 && m_res_cyc > cyc + 2) begin
        CMD_VALID = 0;
        RST = 0;
        #1;
        chk_reset_outputs("async_rst");
        RST = 1;
        m_active = 0;
        m_clr_cyc = -1;
        m_res_cyc = -1;
        m_left = 0;
        floor_c = cyc + 1;
        tick();
        return;
      end
      tick();
      if (m_active) begin
        seen = 1;
        if (!hold) CMD_VALID = 0;
      end
      n++;
    end
    if (n >= 400) begin
      failures++;
      $error("FAIL tile_timeout observed=busy expected=done k=%0d", k);
    end
  endtask
  initial begin
    for (int i = 0; i < D; i++) begin
      acc[i] = 0;
      m_sum[i] = 0;
    end
    #1 RST = 0;
    #1 chk_reset_outputs("reset");
    #1 RST = 1;
    @(posedge CLK);
    #1;
    for (int n = 0; n < 3; n++) tick();
    run_tile(4, 0, 0, 0);
    run_tile(4, 2, 0, 0);
    run_tile(0, 1, 0, 0);
    tick();
    run_tile(3, 1, 1, 0);
    run_tile(3, 1, 0, 0);
    tick();
    run_tile(3, 0, 0, 1);
    run_tile(5, 0, 0, 0);
    tick();
    run_tile(2, 0, 0, 0);
    run_tile(3, 0, 0, 0);
    run_tile(15, 1, 0, 0);
    for (int t = 0; t < 20; t++) begin
      run_tile($urandom_range(0, 15), 1, ($urandom_range(0, 3) == 0), 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    CMD_VALID = 0;
    for (int n = 0; n < 3; n++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sa_feed_ctrl.md
Name: sa_feed_ctrl

Overview:
- Sequencer that sits in front of the sa_2D systolic-array core.
- Accepts a tile command giving the accumulation depth K.
- Pulses an accumulator clear, then streams K operand vector pairs into the array with per-lane diagonal skew, inserting zero bubbles on stalls.
- Drains the array and signals when the YY outputs hold the finished tile.

Parameters:
- HPE, 64, horizontal processing elements (A lanes).
- VPE, 64, vertical processing elements (B lanes).
- WIDTH, 8, operand width per lane.
- KW, 16, width of the K depth field.
- DRAIN_CYC, HPE+VPE+1, cycles from the last operand beat until YY is final.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-low reset.
- CMD_VALID  input  1  tile command valid.
- CMD_READY  output  1  controller can accept a command.
- CMD_K  input  KW  number of operand beats to accumulate.
- OP_VALID  input  1  operand beat valid.
- OP_READY  output  1  controller accepting operand beats.
- OP_A  input  WIDTH*HPE  A operand vector; lane i = bits [WIDTH*i +: WIDTH].
- OP_B  input  WIDTH*VPE  B operand vector; same lane packing.
- SA_A  output  WIDTH*HPE  skewed A vector to core.
- SA_B  output  WIDTH*VPE  skewed B vector to core.
- SA_CLR  output  1  active-high accumulator clear to core.
- RES_VALID  output  1  one-cycle pulse: core YY holds the tile result.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-low.
- Reset (RST=0, async, also mid-operation):
  - FSM goes to IDLE; beat and drain counters clear; all skew registers clear.
  - SA_A=0, SA_B=0, SA_CLR=0, RES_VALID=0, BUSY=0, OP_READY=0, CMD_READY=1.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID=1, latch CMD_K into k_reg and go to CLEAR.
- CLEAR: exactly 1 cycle.
  - SA_CLR=1; all skew registers are zeroed.
  - Next state is FEED if k_reg≠0, else DONE.
- FEED:
  - OP_READY=1.
  - A beat is accepted when OP_VALID=1; its OP_A/OP_B enter the skew line and beat_cnt increments.
  - If OP_VALID=0, an all-zero vector enters instead (bubble); beat_cnt is unchanged.
  - Accepting beat number k_reg moves the FSM to DRAIN and loads drain_cnt=DRAIN_CYC.
  - OP_READY is 0 in all other states.
- DRAIN:
  - Zero vectors enter the skew line; drain_cnt decrements every cycle.
  - When drain_cnt==1, go to DONE. DRAIN therefore lasts exactly DRAIN_CYC cycles.
- DONE: 1 cycle; RES_VALID=1, CMD_READY=0; then go to IDLE.
- Skew:
  - A lane i of an accepted beat appears on SA_A lane i exactly i+1 cycles after acceptance.
  - B lane j appears on SA_B lane j exactly j+1 cycles after acceptance.
  - Skew registers are plain shift registers of depth i+1 (lane 0 is one output register).
  - All outputs are registered.
- Timing, command accepted at cycle t with K back-to-back beats:
  - CLEAR at t+1.
  - Beats accepted t+2 .. t+1+K.
  - DRAIN t+2+K .. t+1+K+DRAIN_CYC.
  - RES_VALID at t+2+K+DRAIN_CYC.
  - Each bubble in FEED shifts all later events by 1 cycle.
- Ordering rules:
  - Commands are never queued. A CMD_VALID seen outside IDLE is ignored and must be held by the requester.
  - An OP_VALID seen outside FEED is not accepted.
- Wrap-around: k_reg = 2^KW−1 is legal. beat_cnt is KW bits and never wraps within a tile.

Test Plan:
1. K=4, HPE=VPE=4, beats A=B={1,2,3,4} per lane, OP_VALID held high:
   - SA_CLR high at t+1.
   - SA_A lane 3 first nonzero at t+6.
   - RES_VALID at t+2+4+9 = t+15.
   - Core YY lane(0,0)=4.
2. Same tile with OP_VALID low on the 2nd FEED cycle:
   - A zero bubble enters the skew line; OP_READY stays 1.
   - RES_VALID at t+16; YY values are unchanged from case 1.
3. CMD_K=0:
   - CLEAR at t+1, RES_VALID at t+2; OP_READY never asserts.
   - SA_A and SA_B stay 0.
4. CMD_VALID held high during FEED and DRAIN:
   - CMD_READY=0 throughout and no second command is latched.
   - The second command is accepted at the IDLE cycle after DONE.
5. Assert RST low during DRAIN:
   - Asynchronously all outputs return to reset values; BUSY=0.
   - A new command after release runs normally with SA_CLR pulse.
6. Back-to-back tiles (K=2 then K=3):
   - A second SA_CLR pulse clears the accumulators.
   - The second result equals an independent K=3 tile with no carry-over.
